// File: rtl/dram_burst_model_pkg.sv
// Shared definitions for the DRAM burst model: request codes, FSM encodings
// and default geometry. Optional feature macro: DRAM_STALL_EN.
package dram_burst_model_pkg;

  localparam logic [1:0] DRAM_REQ_WRITE = 2'd1;
  localparam logic [1:0] DRAM_REQ_READ  = 2'd2;

  localparam int DEF_DATA_W    = 512;
  localparam int DEF_DEPTH_LOG = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/dram_rd_pipe.sv
// Read-latency pipeline: RD_LAT stages of valid+data. The output stage only
// loads on a valid beat, so out_data holds the last beat between bursts.
// empty means no beat is queued behind the output stage.
module dram_rd_pipe #(
  parameter int DATA_W = 512,
  parameter int RD_LAT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              empty
);

  logic [RD_LAT-1:0] vld;
  logic [DATA_W-1:0] dat [RD_LAT];

  // Shift valids every cycle; move data only along with a valid beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int k = 0; k < RD_LAT; k++) dat[k] <= '0;
    end else begin
      vld[0] <= in_valid;
      if (in_valid) dat[0] <= in_data;
      for (int k = 1; k < RD_LAT; k++) begin
        vld[k] <= vld[k-1];
        if (vld[k-1]) dat[k] <= dat[k-1];
      end
    end
  end

  // No beat pending in any stage before the output stage.
  always_comb begin
    empty = 1'b1;
    for (int k = 0; k < RD_LAT - 1; k++) begin
      if (vld[k]) empty = 1'b0;
    end
  end

  assign out_valid = vld[RD_LAT-1];
  assign out_data  = dat[RD_LAT-1];

endmodule

// File: rtl/dram_burst_model.sv
// Cycle-accurate DRAM burst model: block-granular write/read bursts against
// an internal array with RD_LAT read latency. Optional periodic back-pressure
// is enabled by defining DRAM_STALL_EN.
//
// Handshake: a request on D_REQ is taken only in IDLE with D_ELEM != 0.
// D_W is the accept strobe for D_DIN (data committed on that rising edge);
// D_DOUTEN qualifies D_DOUT for exactly one cycle per beat, no ready exists.
module dram_burst_model
  import dram_burst_model_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int DEPTH_LOG    = DEF_DEPTH_LOG,
  parameter int ADDR_STEP    = 8,
  parameter int RD_LAT       = 4,
  parameter int STALL_PERIOD = 8
) (
  input  logic              CLK,
  input  logic              RST_X,
  input  logic [1:0]        D_REQ,
  input  logic [31:0]       D_INITADR,
  input  logic [31:0]       D_ELEM,
  input  logic [DATA_W-1:0] D_DIN,
  output logic              D_W,
  output logic [DATA_W-1:0] D_DOUT,
  output logic              D_DOUTEN,
  output logic              D_BUSY,
  output state_t            dbg_state
);

  localparam int ADDR_SHIFT = $clog2(ADDR_STEP);
  localparam int STALL_W    = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
`ifdef DRAM_STALL_EN
  localparam bit STALL_ON = 1'b1;
`else
  localparam bit STALL_ON = 1'b0;
`endif

  state_t               state, state_nx;
  logic [31:0]          addr, remain;
  logic [DATA_W-1:0]    mem [1 << DEPTH_LOG];
  logic [DEPTH_LOG-1:0] idx;
  logic [STALL_W-1:0]   stall_cnt;
  logic                 stall, issue, pipe_empty;

  // Block index drops the in-block offset bits and wraps at the array depth.
  assign idx = DEPTH_LOG'(addr >> ADDR_SHIFT);

  assign stall     = STALL_ON && (stall_cnt == STALL_W'(STALL_PERIOD - 1));
  assign D_W       = (state == ST_WRITE) && !stall;
  assign issue     = (state == ST_READ) && !stall;
  assign D_BUSY    = (state != ST_IDLE);
  assign dbg_state = state;

  // Free-running stall phase counter.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) stall_cnt <= '0;
    else if (stall_cnt == STALL_W'(STALL_PERIOD - 1)) stall_cnt <= '0;
    else stall_cnt <= stall_cnt + 1'b1;
  end

  // State register plus burst address / remaining-block counters.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state  <= ST_IDLE;
      addr   <= '0;
      remain <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_IDLE) begin
        addr   <= D_INITADR;
        remain <= D_ELEM;
      end else if (D_W || issue) begin
        addr   <= addr + 32'(ADDR_STEP);
        remain <= remain - 32'd1;
      end
    end
  end

  // Next-state logic; a zero-length request is ignored.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (D_ELEM != '0) begin
          if (D_REQ == DRAM_REQ_WRITE)     state_nx = ST_WRITE;
          else if (D_REQ == DRAM_REQ_READ) state_nx = ST_READ;
        end
      end
      ST_WRITE: if (D_W && remain == 32'd1)   state_nx = ST_IDLE;
      ST_READ:  if (issue && remain == 32'd1) state_nx = ST_DRAIN;
      ST_DRAIN: if (pipe_empty)               state_nx = ST_IDLE;
      default:                                state_nx = ST_IDLE;
    endcase
  end

  // Memory array: not reset, so committed beats survive a reset.
  always_ff @(posedge CLK) begin
    if (D_W) mem[idx] <= D_DIN;
  end

  dram_rd_pipe #(
    .DATA_W(DATA_W),
    .RD_LAT(RD_LAT)
  ) u_rd_pipe (
    .clk      (CLK),
    .rst_n    (RST_X),
    .in_valid (issue),
    .in_data  (mem[idx]),
    .out_valid(D_DOUTEN),
    .out_data (D_DOUT),
    .empty    (pipe_empty)
  );

endmodule

// File: tb/tb_dram_burst_model.sv
// Directed bench for dram_burst_model (DATA_W=32, DEPTH_LOG=4, RD_LAT=4).
module tb_dram_burst_model;
  import dram_burst_model_pkg::*;

  localparam int DW   = 32;
  localparam int DL   = 4;
  localparam int STEP = 8;
  localparam int LAT  = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_x;
  logic [1:0]    d_req;
  logic [31:0]   d_initadr, d_elem;
  logic [DW-1:0] d_din, d_dout;
  logic          d_w, d_douten, d_busy;
  state_t        dbg_state;

  dram_burst_model #(
    .DATA_W(DW), .DEPTH_LOG(DL), .ADDR_STEP(STEP), .RD_LAT(LAT), .STALL_PERIOD(4)
  ) dut (
    .CLK(clk), .RST_X(rst_x), .D_REQ(d_req), .D_INITADR(d_initadr),
    .D_ELEM(d_elem), .D_DIN(d_din), .D_W(d_w), .D_DOUT(d_dout),
    .D_DOUTEN(d_douten), .D_BUSY(d_busy), .dbg_state(dbg_state)
  );

  // scoreboard
  int total = 0;
  int bad   = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] model_mem[16];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver: write burst of n blocks, data base+i
  task automatic wr_burst(input logic [31:0] adr, input int n, input logic [31:0] base);
    int cyc;
    int waitc;
    logic [3:0] blk;
    d_req = DRAM_REQ_WRITE; d_initadr = adr; d_elem = n; d_din = base;
    step();
    d_req = 2'd0;
    cyc = 1;
    chk("wr_busy", 32'(d_busy), 1);
    for (int i = 0; i < n; i++) begin
      d_din = base + i;
      waitc = 0;
      while (!d_w && waitc < 8) begin step(); waitc++; cyc++; end
      chk("wr_beat", 32'(d_w), 1);
      blk = 4'(adr / STEP + i);
      model_mem[blk] = base + i;
      step();
      cyc++;
    end
`ifndef DRAM_STALL_EN
    chk("wr_len", cyc, n + 1);
`endif
    chk("wr_done", 32'(d_busy), 0);
  endtask

  // driver + checker: read burst of n blocks against the model
  task automatic rd_burst(input logic [31:0] adr, input int n, input string tag);
    int first, last, beats, endc;
    logic [31:0] e;
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(model_mem[4'(adr / STEP + i)]);
    d_req = DRAM_REQ_READ; d_initadr = adr; d_elem = n;
    step();
    d_req = 2'd0;
    first = -1; last = -1; beats = 0; endc = -1;
    for (int c = 1; c <= 80; c++) begin
      if (d_douten) begin
        if (first < 0) first = c;
        last = c;
        beats++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk({tag, "_data"}, d_dout, e);
        end else begin
          chk({tag, "_extra"}, 32'(d_douten), 0);
        end
      end
      if (!d_busy) begin endc = c; break; end
      step();
    end
    chk({tag, "_timeout"}, 32'(endc < 0), 0);
    chk({tag, "_beats"}, beats, n);
`ifndef DRAM_STALL_EN
    chk({tag, "_first"}, first, 1 + LAT);
    chk({tag, "_last"}, last, n + LAT);
    chk({tag, "_end"}, endc, n + LAT + 1);
`endif
  endtask

  initial begin
    int quiet;
    int nb;
    logic [2:0] exp_bits;
    rst_x = 1'b0; d_req = 2'd0; d_initadr = '0; d_elem = '0; d_din = '0;

    // reset state
    #2;
    chk("rst_busy", 32'(d_busy), 0);
    chk("rst_w", 32'(d_w), 0);
    chk("rst_douten", 32'(d_douten), 0);
    chk("rst_dout", d_dout, 0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    step(); step();
    rst_x = 1'b1;
    step();

    // write A0..A3 at 0x40, read them back
    wr_burst(32'h40, 4, 32'hA0);
    rd_burst(32'h40, 4, "rd4");
    step(); step();
    chk("hold_dout", d_dout, 32'hA3);
    chk("hold_en", 32'(d_douten), 0);

    // reset in the middle of a write burst
    d_req = DRAM_REQ_WRITE; d_initadr = 32'h0; d_elem = 4; d_din = 32'h11;
    step();
    d_req = 2'd0;
    nb = 0;
    for (int k = 0; k < 2; k++) begin
      d_din = 32'h11 + nb;
      if (d_w) begin model_mem[4'(nb)] = 32'h11 + nb; nb++; end
      step();
    end
    rst_x = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(d_busy), 0);
    chk("mid_rst_w", 32'(d_w), 0);
    chk("mid_rst_dout", d_dout, 0);
    chk("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    step(); step();
    rst_x = 1'b1;
    step();
    rd_burst(32'h0, nb, "after_rst");

    // wrap: blocks 15, 0, 1
    wr_burst(32'h78, 3, 32'hB0);
    rd_burst(32'h78, 3, "wrap");
    rd_burst(32'h00, 1, "wrap0");
    chk("wrap0_val", model_mem[0], 32'hB1);
    rd_burst(32'h48, 1, "keep");

    // zero-length read is ignored
    d_req = DRAM_REQ_READ; d_initadr = 32'h40; d_elem = 0;
    quiet = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (d_busy || d_douten) quiet++;
    end
    d_req = 2'd0;
    chk("zero_elem", quiet, 0);

`ifndef DRAM_STALL_EN
    // read request held through a write burst starts on the first IDLE cycle
    d_req = DRAM_REQ_WRITE; d_initadr = 32'h20; d_elem = 2; d_din = 32'hC0;
    step();
    d_req = DRAM_REQ_READ;
    model_mem[4] = 32'hC0;
    model_mem[5] = 32'hC1;
    for (int c = 1; c <= 11; c++) begin
      d_din = (c == 2) ? 32'hC1 : 32'hC0;
      if (c == 4) d_req = 2'd0;
      exp_bits[2] = (c <= 2) || (c >= 4 && c <= 9);
      exp_bits[1] = (c <= 2);
      exp_bits[0] = (c == 8) || (c == 9);
      chk("held_bw_en", 32'({d_busy, d_w, d_douten}), 32'(exp_bits));
      if (c == 8) chk("held_d0", d_dout, 32'hC0);
      if (c == 9) chk("held_d1", d_dout, 32'hC1);
      step();
    end
`else
    // back-pressure: 8-block burst still returns 8 beats in order
    wr_burst(32'h00, 8, 32'hD0);
    rd_burst(32'h00, 8, "stall");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
